// File: rtl/control_miscare_pkg.sv
// Shared types and constants for the line-follower motion sequencer:
// state codes, H-bridge direction encodings and sensor bit positions.
package control_miscare_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INAINTE  = 3'd1,
    DREAPTA  = 3'd2,
    STANGA   = 3'd3,
    CAUTA_DR = 3'd4,
    CAUTA_ST = 3'd5,
    INAPOI   = 3'd6,
    OPRIT    = 3'd7
  } stare_t;

  typedef enum logic [1:0] {
    MEM_NICI = 2'd0,
    MEM_DR   = 2'd1,
    MEM_ST   = 2'd2
  } memorie_t;

  localparam logic [1:0] DIR_FWD = 2'b10;
  localparam logic [1:0] DIR_REV = 2'b01;
  localparam logic [1:0] DIR_OFF = 2'b00;

  localparam int S_EXT_DR = 0;
  localparam int S_INT_DR = 1;
  localparam int S_CENTRU = 2;
  localparam int S_INT_ST = 3;
  localparam int S_EXT_ST = 4;

  // Commanded {driver A, driver B} for a state, before dead-time insertion.
  function automatic logic [3:0] comanda_stare(input stare_t s);
    logic [3:0] c;
    c = {DIR_OFF, DIR_OFF};
    case (s)
      INAINTE:           c = {DIR_FWD, DIR_FWD};
      DREAPTA, CAUTA_DR: c = {DIR_REV, DIR_FWD};
      STANGA, CAUTA_ST:  c = {DIR_FWD, DIR_REV};
      INAPOI:            c = {DIR_REV, DIR_REV};
      default:           c = {DIR_OFF, DIR_OFF};
    endcase
    return c;
  endfunction

  // Turn-signal pattern {right, left} for a state and blink phase.
  function automatic logic [1:0] semnal_stare(input stare_t s, input logic faza);
    logic [1:0] r;
    r = 2'b00;
    case (s)
      DREAPTA, CAUTA_DR: r = {faza, 1'b0};
      STANGA, CAUTA_ST:  r = {1'b0, faza};
      INAPOI:            r = {faza, faza};
      OPRIT:             r = 2'b11;
      default:           r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_miscare_fsm_timp_mort.sv
// Dead-time output stage for one H-bridge: a direct forward<->reverse
// reversal is replaced by DEAD_TIME cycles of off before the new command.
module timp_mort
  import control_miscare_pkg::*;
#(
  parameter int DEAD_TIME = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       oprire,
  input  logic [1:0] comanda,
  output logic [1:0] iesire
);

  localparam int CW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

  logic [CW-1:0] cnt;
  logic          activ;

  // While a dead-time runs, further nonzero changes only update what is
  // sampled at expiry; they never restart the count.
  always_ff @(posedge clk) begin
    if (!rst_n || oprire) begin
      iesire <= DIR_OFF;
      cnt    <= '0;
      activ  <= 1'b0;
    end else if (activ) begin
      if (comanda == DIR_OFF) begin
        activ <= 1'b0;
        cnt   <= '0;
      end else if (cnt == CW'(DEAD_TIME - 1)) begin
        iesire <= comanda;
        activ  <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (comanda != iesire && comanda != DIR_OFF && iesire != DIR_OFF) begin
      iesire <= DIR_OFF;
      activ  <= 1'b1;
      cnt    <= '0;
    end else begin
      iesire <= comanda;
    end
  end

endmodule

// File: rtl/control_miscare_fsm.sv
// Line-follower motion sequencer: sensor sync/debounce, tracking FSM and
// per-driver dead-time. Turn signals are built only with SEMNALIZARE_EN.
module control_miscare_fsm
  import control_miscare_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEAD_TIME       = 8,
  parameter int SEARCH_TIMEOUT  = 1000,
  parameter int REVERSE_TIME    = 500
`ifdef SEMNALIZARE_EN
  ,
  parameter int BLINK_HALF      = 250
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [4:0] senzor,
  output logic [1:0] directie_driverA,
  output logic [1:0] directie_driverB,
  output logic [2:0] stare,
  output logic       linie_pierduta,
  output logic       semnal_dreapta,
  output logic       semnal_stanga
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX = (SEARCH_TIMEOUT > REVERSE_TIME) ? SEARCH_TIMEOUT : REVERSE_TIME;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [4:0]    sync1, sync2, filt;
  logic [DW-1:0] db_cnt [5];
  stare_t        stare_q, stare_next;
  memorie_t      memorie;
  logic [TW-1:0] timer;
  logic [3:0]    cmd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= senzor;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          filt[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    stare_next = stare_q;
    if (!enable) begin
      stare_next = IDLE;
    end else begin
      case (stare_q)
        IDLE: stare_next = INAINTE;
        INAINTE, DREAPTA, STANGA: begin
          if (filt[S_CENTRU]) begin
            if (filt[S_INT_DR] && !filt[S_INT_ST])      stare_next = DREAPTA;
            else if (filt[S_INT_ST] && !filt[S_INT_DR]) stare_next = STANGA;
            else                                        stare_next = INAINTE;
          end else begin
            case (memorie)
              MEM_DR:  stare_next = CAUTA_DR;
              MEM_ST:  stare_next = CAUTA_ST;
              default: stare_next = INAPOI;
            endcase
          end
        end
        CAUTA_DR, CAUTA_ST: begin
          if (filt[S_CENTRU])                          stare_next = INAINTE;
          else if (timer == TW'(SEARCH_TIMEOUT - 1))   stare_next = INAPOI;
        end
        INAPOI: begin
          if (filt[S_CENTRU])                          stare_next = INAINTE;
          else if (timer == TW'(REVERSE_TIME - 1))     stare_next = OPRIT;
        end
        default: stare_next = stare_q;
      endcase
    end
  end

  // Turn memory is the registered value, so a transition uses what was
  // learned up to the previous cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stare_q        <= IDLE;
      memorie        <= MEM_NICI;
      timer          <= '0;
      linie_pierduta <= 1'b0;
    end else begin
      stare_q        <= stare_next;
      linie_pierduta <= (stare_next == OPRIT);
      if (stare_next != stare_q)  timer <= '0;
      else if (timer != '1)       timer <= timer + 1'b1;
      if (stare_q != IDLE) begin
        if ((filt[S_EXT_DR] || filt[S_INT_DR]) && !(filt[S_INT_ST] || filt[S_EXT_ST]))
          memorie <= MEM_DR;
        else if ((filt[S_INT_ST] || filt[S_EXT_ST]) && !(filt[S_EXT_DR] || filt[S_INT_DR]))
          memorie <= MEM_ST;
      end
    end
  end

  assign stare = stare_q;
  assign cmd   = comanda_stare(stare_q);

  timp_mort #(.DEAD_TIME(DEAD_TIME)) u_mort_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .oprire  (!enable),
    .comanda (cmd[3:2]),
    .iesire  (directie_driverA)
  );

  timp_mort #(.DEAD_TIME(DEAD_TIME)) u_mort_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .oprire  (!enable),
    .comanda (cmd[1:0]),
    .iesire  (directie_driverB)
  );

`ifdef SEMNALIZARE_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [BW-1:0] blink_cnt;
  logic          faza;

  // Signals are decoded from the next state so they line up with stare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt      <= '0;
      faza           <= 1'b0;
      semnal_dreapta <= 1'b0;
      semnal_stanga  <= 1'b0;
    end else if (stare_next != stare_q) begin
      blink_cnt <= '0;
      faza      <= 1'b1;
      {semnal_dreapta, semnal_stanga} <= semnal_stare(stare_next, 1'b1);
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      faza      <= ~faza;
      {semnal_dreapta, semnal_stanga} <= semnal_stare(stare_next, ~faza);
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      {semnal_dreapta, semnal_stanga} <= semnal_stare(stare_next, faza);
    end
  end
`else
  assign semnal_dreapta = 1'b0;
  assign semnal_stanga  = 1'b0;
`endif

endmodule
